// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game core input path: direction codes, button
// index constants and the fixed-priority request picker.
// -----------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  // Bit positions inside the {UP, DOWN, LEFT, RIGHT} button vectors.
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;
  localparam int NUM_BTN   = 4;

  typedef struct packed {
    logic valid;
    dir_e dir;
  } req_t;

  // Opposite pairs differ only in the LSB (UP/DOWN, LEFT/RIGHT).
  function automatic dir_e opposite_dir(input dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction

  // Fixed priority UP > DOWN > LEFT > RIGHT among simultaneous press pulses.
  function automatic req_t prio_pick(input logic [NUM_BTN-1:0] press);
    req_t r;
    r.valid = |press;
    if (press[BTN_UP]) begin
      r.dir = DIR_UP;
    end else if (press[BTN_DOWN]) begin
      r.dir = DIR_DOWN;
    end else if (press[BTN_LEFT]) begin
      r.dir = DIR_LEFT;
    end else begin
      r.dir = DIR_RIGHT;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser, counter-based debounce and press-pulse generator for a
// single asynchronous active-high button.
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset
//   pin_i    : raw button pin (asynchronous)
//   level_o  : debounced level (registered)
//   press_o  : one-cycle pulse, high in the same cycle level_o rises
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic level_o,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Debounce next state: count consecutive disagreeing samples, flip on the last.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = CNT_ZERO;
      // Only a rising level is a press.
      press_d = ~level_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Synchroniser and debounce state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/joy_dir_input.sv
// -----------------------------------------------------------------------------
// joy_dir_input
// Player input front end: debounces the four direction buttons, picks one
// request per cycle by fixed priority, filters reversals of the committed
// direction and commits the pending direction on the frame tick.
//   sys_clk       : system clock
//   sys_reset_n   : asynchronous active-low reset
//   res_y_one     : raw UP button      res_y_two : raw DOWN button
//   res_x_one     : raw LEFT button    res_x_two : raw RIGHT button
//   frame_tick    : one-cycle pulse per game frame
//   dir_out       : committed direction (00 UP, 01 DOWN, 10 LEFT, 11 RIGHT)
//   dir_changed   : one-cycle pulse when dir_out took a different value
//   btn_level     : debounced levels {UP, DOWN, LEFT, RIGHT}
//   pending_valid : a request is latched and waiting for frame_tick
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module joy_dir_input
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19,
  parameter bit          REVERSE_LOCK    = 1'b1,
  parameter logic [1:0]  RESET_DIR       = 2'b11
) (
  input  logic       sys_clk,
  input  logic       sys_reset_n,
  input  logic       res_y_one,
  input  logic       res_y_two,
  input  logic       res_x_one,
  input  logic       res_x_two,
  input  logic       frame_tick,
  output logic [1:0] dir_out,
  output logic       dir_changed,
  output logic [3:0] btn_level,
  output logic       pending_valid
);

  logic [NUM_BTN-1:0] pin_s;
  logic [NUM_BTN-1:0] level_s;
  logic [NUM_BTN-1:0] press_s;

  assign pin_s[BTN_UP]    = res_y_one;
  assign pin_s[BTN_DOWN]  = res_y_two;
  assign pin_s[BTN_LEFT]  = res_x_one;
  assign pin_s[BTN_RIGHT] = res_x_two;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_btn_debounce (
      .clk_i   (sys_clk),
      .rst_ni  (sys_reset_n),
      .pin_i   (pin_s[g]),
      .level_o (level_s[g]),
      .press_o (press_s[g])
    );
  end

  dir_e dir_q;
  dir_e dir_d;
  dir_e pend_dir_q;
  dir_e pend_dir_d;
  logic pend_valid_q;
  logic pend_valid_d;
  logic changed_q;
  logic changed_d;

  req_t req_s;
  logic req_locked_s;
  logic pend_locked_s;
  logic accept_s;

  // Request selection and reversal filtering, both against committed dir_q.
  always_comb begin
    req_s         = prio_pick(press_s);
    req_locked_s  = REVERSE_LOCK && (req_s.dir == opposite_dir(dir_q));
    pend_locked_s = REVERSE_LOCK && (pend_dir_q == opposite_dir(dir_q));
    accept_s      = req_s.valid && !req_locked_s;
  end

  // Commit and pending-register next state.
  always_comb begin
    dir_d        = dir_q;
    changed_d    = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    // The tick commits what was pending before this cycle; a pending entry that
    // became a reversal after an earlier commit is discarded instead.
    if (frame_tick && pend_valid_q) begin
      pend_valid_d = 1'b0;
      if (!pend_locked_s) begin
        dir_d     = pend_dir_q;
        changed_d = (pend_dir_q != dir_q);
      end else begin
        dir_d = dir_q;
      end
    end else begin
      pend_valid_d = pend_valid_q;
    end
    // A request in the tick cycle survives as the new pending entry.
    if (accept_s) begin
      pend_dir_d   = req_s.dir;
      pend_valid_d = 1'b1;
    end else begin
      pend_dir_d = pend_dir_q;
    end
  end

  // Direction, pending and change-pulse registers.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      dir_q        <= dir_e'(RESET_DIR);
      pend_dir_q   <= dir_e'(RESET_DIR);
      pend_valid_q <= 1'b0;
      changed_q    <= 1'b0;
    end else begin
      dir_q        <= dir_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      changed_q    <= changed_d;
    end
  end

  assign dir_out       = dir_q;
  assign dir_changed   = changed_q;
  assign btn_level     = level_s;
  assign pending_valid = pend_valid_q;

endmodule

// File: tb/tb_joy_dir_input.sv
// Self-checking bench for joy_dir_input with DEBOUNCE_CYCLES=4.
module tb_joy_dir_input;

  localparam int D = 4;

  logic       sys_clk;
  logic       sys_reset_n;
  logic       res_y_one, res_y_two, res_x_one, res_x_two;
  logic       frame_tick;
  logic [1:0] dir_out;
  logic       dir_changed;
  logic [3:0] btn_level;
  logic       pending_valid;

  int n_cmp;
  int n_bad;

  joy_dir_input #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3),
    .REVERSE_LOCK    (1'b1),
    .RESET_DIR       (2'b11)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_reset_n   (sys_reset_n),
    .res_y_one     (res_y_one),
    .res_y_two     (res_y_two),
    .res_x_one     (res_x_one),
    .res_x_two     (res_x_two),
    .frame_tick    (frame_tick),
    .dir_out       (dir_out),
    .dir_changed   (dir_changed),
    .btn_level     (btn_level),
    .pending_valid (pending_valid)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- reference model ----------------
  // pin history per button: ph[b][j] = pin value sampled j edges ago
  bit         ph [4][D+2];
  logic [3:0] m_lvl;
  logic [3:0] m_press;
  logic [1:0] m_dir;
  logic [1:0] m_pend;
  bit         m_pv;
  bit         m_chg;

  task automatic model_reset();
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < D + 2; j++) ph[b][j] = 1'b0;
    m_lvl = 4'b0000; m_press = 4'b0000;
    m_dir = 2'b11; m_pend = 2'b11; m_pv = 1'b0; m_chg = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] pins, input bit ft);
    bit         req_v;
    bit         accept;
    logic [1:0] req;
    int         top;
    bit         all_diff;
    // highest pressed index wins; index 3 (UP) maps to code 0
    req_v = (m_press != 4'b0000);
    top = 0;
    for (int b = 0; b < 4; b++) if (m_press[b]) top = b;
    req = 2'(3 - top);
    accept = req_v && (req != (m_dir ^ 2'b01));
    m_chg = 1'b0;
    if (ft && m_pv) begin
      if (m_pend != (m_dir ^ 2'b01)) begin
        m_chg = (m_pend != m_dir);
        m_dir = m_pend;
      end
      m_pv = 1'b0;
    end
    if (accept) begin
      m_pend = req;
      m_pv   = 1'b1;
    end
    // a level flips once the last D synchronised samples all disagree with it
    for (int b = 0; b < 4; b++) begin
      for (int j = D + 1; j > 0; j--) ph[b][j] = ph[b][j-1];
      ph[b][0] = pins[b];
      all_diff = 1'b1;
      for (int j = 2; j <= D + 1; j++) if (ph[b][j] == m_lvl[b]) all_diff = 1'b0;
      m_press[b] = 1'b0;
      if (all_diff) begin
        m_press[b] = ~m_lvl[b];
        m_lvl[b]   = ~m_lvl[b];
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("dir_out",       {2'b00, dir_out},       {2'b00, m_dir});
    chk("btn_level",     btn_level,              m_lvl);
    chk("pending_valid", {3'b000, pending_valid}, {3'b000, m_pv});
    chk("dir_changed",   {3'b000, dir_changed},  {3'b000, m_chg});
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_dir"},   {2'b00, dir_out},        4'b0011);
    chk({tag, "_level"}, btn_level,               4'b0000);
    chk({tag, "_pv"},    {3'b000, pending_valid}, 4'b0000);
    chk({tag, "_chg"},   {3'b000, dir_changed},   4'b0000);
  endtask

  // one clock: drive on negedge, step model on posedge, sample 1 time unit later
  task automatic cycle(input logic [3:0] pins, input bit ft);
    @(negedge sys_clk);
    {res_y_one, res_y_two, res_x_one, res_x_two} = pins;
    frame_tick = ft;
    @(posedge sys_clk);
    model_step(pins, ft);
    #1;
    compare_all();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0] pins;
    bit         tick;     // frame_tick on the last cycle of the step
    int         n;
    logic [1:0] exp_dir;
    logic [3:0] exp_lvl;
    bit         exp_pv;
  } step_t;

  step_t tbl[$];

  function automatic step_t mk(input logic [3:0] p, input bit t, input int n,
                               input logic [1:0] d, input logic [3:0] l, input bit v);
    step_t s;
    s.pins = p; s.tick = t; s.n = n; s.exp_dir = d; s.exp_lvl = l; s.exp_pv = v;
    return s;
  endfunction

  initial begin
    logic [3:0] rp;
    bit         rft;
    int         lat;
    bit         seen;

    n_cmp = 0; n_bad = 0;
    sys_reset_n = 1'b0;
    {res_y_one, res_y_two, res_x_one, res_x_two} = 4'b0000;
    frame_tick = 1'b0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    sys_reset_n = 1'b1;
    #1;
    check_reset_values("reset");

    // idle ticks
    tbl.push_back(mk(4'b0000, 1'b1, 3, 2'b11, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b1, 3, 2'b11, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b1, 3, 2'b11, 4'b0000, 1'b0));
    // glitch on RIGHT shorter than the debounce window
    tbl.push_back(mk(4'b0001, 1'b0, 3, 2'b11, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 6, 2'b11, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b1, 1, 2'b11, 4'b0000, 1'b0));
    // LEFT is the reverse of RIGHT: dropped
    tbl.push_back(mk(4'b0010, 1'b0, 8, 2'b11, 4'b0010, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 8, 2'b11, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b1, 1, 2'b11, 4'b0000, 1'b0));
    // UP held 10 cycles then tick
    tbl.push_back(mk(4'b1000, 1'b0, 10, 2'b11, 4'b1000, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b1, 1, 2'b00, 4'b1000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 8, 2'b00, 4'b0000, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b1, 1, 2'b00, 4'b0000, 1'b0));
    // RIGHT from UP
    tbl.push_back(mk(4'b0001, 1'b0, 8, 2'b00, 4'b0001, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b1, 1, 2'b11, 4'b0001, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 8, 2'b11, 4'b0000, 1'b0));
    // DOWN and LEFT together: DOWN wins
    tbl.push_back(mk(4'b0110, 1'b0, 8, 2'b11, 4'b0110, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b1, 1, 2'b01, 4'b0110, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 8, 2'b01, 4'b0000, 1'b0));
    // back to RIGHT
    tbl.push_back(mk(4'b0001, 1'b0, 8, 2'b01, 4'b0001, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b1, 1, 2'b11, 4'b0001, 1'b0));
    tbl.push_back(mk(4'b0000, 1'b0, 8, 2'b11, 4'b0000, 1'b0));
    // UP pending, DOWN press coincides with tick
    tbl.push_back(mk(4'b1000, 1'b0, 7, 2'b11, 4'b1000, 1'b1));
    tbl.push_back(mk(4'b0100, 1'b1, 7, 2'b00, 4'b0100, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b0, 8, 2'b00, 4'b0000, 1'b1));
    tbl.push_back(mk(4'b0000, 1'b1, 1, 2'b00, 4'b0000, 1'b0));
    // leave a LEFT request pending before the reset test
    tbl.push_back(mk(4'b0010, 1'b0, 8, 2'b00, 4'b0010, 1'b1));

    foreach (tbl[k]) begin
      for (int i = 0; i < tbl[k].n; i++) cycle(tbl[k].pins, tbl[k].tick && (i == tbl[k].n - 1));
      chk($sformatf("row%0d_dir", k),   {2'b00, dir_out},        {2'b00, tbl[k].exp_dir});
      chk($sformatf("row%0d_level", k), btn_level,               tbl[k].exp_lvl);
      chk($sformatf("row%0d_pv", k),    {3'b000, pending_valid}, {3'b000, tbl[k].exp_pv});
    end

    // reset asserted with DOWN mid-count and LEFT pending
    repeat (3) cycle(4'b0110, 1'b0);
    #2;
    sys_reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_values("midreset");
    repeat (2) @(negedge sys_clk);
    {res_y_one, res_y_two, res_x_one, res_x_two} = 4'b0000;
    sys_reset_n = 1'b1;
    #1;
    check_reset_values("release");
    repeat (3) cycle(4'b0000, 1'b0);

    // UP latency: level must rise on the 6th edge after the pin edge
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      cycle(4'b1000, 1'b0);
      if (btn_level[3]) begin seen = 1'b1; lat = i; end
    end
    chk("up_latency", 4'(lat), 4'(D + 2));
    cycle(4'b1000, 1'b0);
    chk("up_pending", {3'b000, pending_valid}, 4'b0001);
    cycle(4'b1000, 1'b1);
    chk("up_commit_dir", {2'b00, dir_out}, 4'b0000);
    chk("up_chg_pulse", {3'b000, dir_changed}, 4'b0001);
    cycle(4'b1000, 1'b0);
    chk("up_chg_single", {3'b000, dir_changed}, 4'b0000);
    cycle(4'b1000, 1'b1);
    chk("up_second_tick", {3'b000, dir_changed}, 4'b0000);
    chk("up_second_dir", {2'b00, dir_out}, 4'b0000);

    // random phase against the model
    rp = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(9) == 0) rp[b] = ~rp[b];
      rft = ($urandom_range(7) == 0);
      cycle(rp, rft);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
